imem_responder: RTL

Instruction-memory responder at the slave end of the fetch bus that the fetch unit drives with `imem_req_valid` / `imem_req_ready` / `imem_req`. It accepts word-aligned `MEM_READ` requests and reads a synchronous single-port instruction SRAM. Read data and error status go into a small response FIFO, which returns them in order on a valid/ready response channel. It also supports a flush that discards all in-flight fetches.

---
 rtl/imem_responder.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/imem_responder.sv
// Instruction-memory responder: classifies fetch requests, reads a synchronous
// SRAM and returns in-order {data, err} responses through a small credit-tracked FIFO.

package imem_pkg;
  typedef enum logic [1:0] {
    MEM_READ  = 2'd0,
    MEM_WRITE = 2'd1,
    MEM_AMO   = 2'd2,
    MEM_FENCE = 2'd3
  } mem_type_e;

  typedef struct packed {
    mem_type_e   req_type;
    logic [31:0] req_addr;
    logic [3:0]  req_burst;
  } mem_req_t;
endpackage

module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned AW         = 12,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          imem_req_valid,
  output logic          imem_req_ready,
  input  mem_req_t      imem_req,
  output logic          imem_resp_valid,
  input  logic          imem_resp_ready,
  output logic [31:0]   imem_resp_data,
  output logic          imem_resp_err,
  output logic          sram_en,
  output logic [AW-1:0] sram_addr,
  input  logic [31:0]   sram_rdata
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 2);
  localparam logic [32:0] LO_ADDR = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI_ADDR = LO_ADDR + (33'd4 << AW);

  logic [CW-1:0] occ_q, occ_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          pend_q, pend_d;
  logic          pend_err_q, pend_err_d;
  logic [32:0]   fifo_q [FIFO_DEPTH];

  logic [32:0]   addr_ext;
  logic          req_err;
  logic          accept;
  logic          push;
  logic          pop;
  logic [32:0]   push_entry;
  logic [32:0]   head_entry;
  logic          unused_burst;

  assign unused_burst = ^imem_req.req_burst;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Range check in 33 bits so a window ending at 4 GiB cannot wrap to zero.
  assign addr_ext = {1'b0, imem_req.req_addr};
  assign req_err  = (imem_req.req_type != MEM_READ)
                 || (imem_req.req_addr[1:0] != 2'b00)
                 || (addr_ext < LO_ADDR)
                 || (addr_ext >= HI_ADDR);

  // Credits count both queued entries and the read still in the SRAM pipe.
  assign imem_req_ready = !flush && ((occ_q + CW'(pend_q)) < CW'(FIFO_DEPTH));
  assign accept         = imem_req_valid && imem_req_ready;

  assign sram_en   = accept && !req_err;
  assign sram_addr = AW'((imem_req.req_addr - BASE_ADDR) >> 2);

  assign push       = pend_q && !flush;
  assign push_entry = pend_err_q ? {1'b1, 32'h0} : {1'b0, sram_rdata};

  assign head_entry      = (occ_q != '0) ? fifo_q[rptr_q] : 33'h0;
  assign imem_resp_valid = (occ_q != '0) && !flush;
  assign imem_resp_data  = head_entry[31:0];
  assign imem_resp_err   = head_entry[32];
  assign pop             = imem_resp_valid && imem_resp_ready;

  always_comb begin
    occ_d      = occ_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    pend_d     = accept;
    pend_err_d = accept && req_err;
    if (flush) begin
      occ_d  = '0;
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push) wptr_d = ptr_inc(wptr_q);
      if (pop)  rptr_d = ptr_inc(rptr_q);
      case ({push, pop})
        2'b10:   occ_d = occ_q + CW'(1);
        2'b01:   occ_d = occ_q - CW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      pend_q     <= 1'b0;
      pend_err_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      pend_q     <= pend_d;
      pend_err_q <= pend_err_d;
    end
  end

  generate
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          fifo_q[gi] <= 33'h0;
        end else if (push && (wptr_q == PW'(gi))) begin
          fifo_q[gi] <= push_entry;
        end
      end
    end
  endgenerate

endmodule
